mbist_diagnosis_ready_array: RTL and testbench

- Parametrised next generation of the MBIST diagnosis-ready IJTAG node.
- Aggregates NUM_CTL per-controller diagnosis-ready flags plus one auxiliary flag into a single stable_block output.
- Adds a per-channel enable mask, an optional debounce (stability counter) mode, and a sticky "ready dropped" flag.
- All configuration and status are accessed through a SIB-gated TDR on the IJTAG network.

---
 rtl/mbist_diagnosis_ready_array.sv | 108 ++++++++++
 tb/tb_mbist_diagnosis_ready_array.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mbist_diagnosis_ready_array.sv
// IJTAG node that merges masked per-controller diagnosis-ready flags with an auxiliary flag,
// with an optional debounce counter and a sticky "ready dropped" flag, all behind a SIB-gated TDR.
module mbist_diagnosis_ready_array #(
    parameter int NUM_CTL       = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic               ijtag_tck,
    input  logic               ijtag_reset,
    input  logic               ijtag_sel,
    input  logic               ijtag_si,
    input  logic               ijtag_ce,
    input  logic               ijtag_se,
    input  logic               ijtag_ue,
    output logic               ijtag_so,
    input  logic [NUM_CTL-1:0] diag_ready_ctl_in,
    input  logic               diag_ready_aux_in,
    output logic               stable_block
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic               sib;
    logic               sib_latch;
    logic [NUM_CTL:0]   tdr;
    logic [NUM_CTL:0]   tdr_nr;
    logic [CNT_W-1:0]   cnt;
    logic               sticky_drop;
    logic               so_q;
    logic               tdr_select;
    logic [NUM_CTL-1:0] en;
    logic               dbe;
    logic               ready_raw;
    logic               cnt_full;

    assign tdr_select = ijtag_sel & sib_latch;
    assign en         = tdr_nr[NUM_CTL-1:0];
    assign dbe        = tdr_nr[NUM_CTL];
    assign ready_raw  = diag_ready_aux_in & (&(~en | diag_ready_ctl_in));
    assign cnt_full   = (cnt == CNT_MAX);

    // Debounce mode only exposes the registered counter state, so the output cannot glitch.
    assign stable_block = dbe ? cnt_full : ready_raw;
    assign ijtag_so     = so_q;

    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            tdr <= '0;
        end else if (tdr_select) begin
            if (ijtag_ce)
                tdr <= {sticky_drop, diag_ready_ctl_in};
            else if (ijtag_se)
                tdr <= {ijtag_si, tdr[NUM_CTL:1]};
        end
    end

    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            sib <= 1'b0;
        end else if (ijtag_sel) begin
            if (ijtag_ce)
                sib <= stable_block;
            else if (ijtag_se)
                sib <= sib_latch ? tdr[0] : ijtag_si;
        end
    end

    always_ff @(negedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            tdr_nr    <= '0;
            sib_latch <= 1'b0;
        end else begin
            if (ijtag_ue && tdr_select)
                tdr_nr <= tdr;
            if (ijtag_ue && ijtag_sel)
                sib_latch <= sib;
        end
    end

    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            cnt <= '0;
        end else if (!dbe || !ready_raw) begin
            cnt <= '0;
        end else if (!cnt_full) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // The capture has already loaded the old flag into the TDR, so clearing here loses nothing;
    // a drop on the same edge still wins.
    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset)
            sticky_drop <= 1'b0;
        else if (dbe && cnt_full && !ready_raw)
            sticky_drop <= 1'b1;
        else if (ijtag_ce && tdr_select)
            sticky_drop <= 1'b0;
    end

    always_latch begin
        if (ijtag_reset)
            so_q <= 1'b0;
        else if (!ijtag_tck)
            so_q <= sib;
    end

endmodule

// File: tb/tb_mbist_diagnosis_ready_array.sv
// Directed bench for mbist_diagnosis_ready_array: mask table, debounce timing, sticky flag,
// scan-out ordering and asynchronous reset.
module tb_mbist_diagnosis_ready_array;

    logic       tck = 1'b0;
    logic       rst, sel, si, ce, se, ue;
    logic       so;
    logic [3:0] ctl;
    logic       aux;
    logic       stable;

    int nvec = 0;
    int nerr = 0;
    logic so_seen, so_hi;

    typedef struct {
        logic [4:0] cfg;
        logic [3:0] ctl;
        logic       aux;
        logic       exp;
    } vec_t;

    vec_t vecs [10];

    mbist_diagnosis_ready_array #(.NUM_CTL(4), .STABLE_CYCLES(8), .CNT_W(4)) dut (
        .ijtag_tck        (tck),
        .ijtag_reset      (rst),
        .ijtag_sel        (sel),
        .ijtag_si         (si),
        .ijtag_ce         (ce),
        .ijtag_se         (se),
        .ijtag_ue         (ue),
        .ijtag_so         (so),
        .diag_ready_ctl_in(ctl),
        .diag_ready_aux_in(aux),
        .stable_block     (stable)
    );

    always #5 tck = ~tck;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One tck cycle: drive at posedge+1, sample so while tck low and again while tck high.
    task automatic step(input logic c, input logic s, input logic u, input logic d);
        ce = c; se = s; ue = u; si = d;
        @(negedge tck); #1 so_seen = so;
        @(posedge tck); #1 so_hi = so;
        ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
    endtask

    // Assumes the SIB is open; leaves it open and loads cfg into the update stage.
    task automatic program_cfg(input logic [4:0] cfg);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, cfg[i]);
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Bit 0 = sib, bits 1..4 = tdr[0..3], bit 5 = tdr[4].
    task automatic read_chain(input string tag, input logic [5:0] exp);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            check($sformatf("%s_bit%0d", tag, k), so_seen, exp[k]);
            check($sformatf("%s_hold%0d", tag, k), so_hi, exp[k]);
        end
    endtask

    initial begin
        vecs[0] = '{5'b00101, 4'b1010, 1'b1, 1'b0};
        vecs[1] = '{5'b00101, 4'b0101, 1'b1, 1'b1};
        vecs[2] = '{5'b00101, 4'b0101, 1'b0, 1'b0};
        vecs[3] = '{5'b00000, 4'b0000, 1'b1, 1'b1};
        vecs[4] = '{5'b01111, 4'b1111, 1'b1, 1'b1};
        vecs[5] = '{5'b01111, 4'b1110, 1'b1, 1'b0};
        vecs[6] = '{5'b01000, 4'b0111, 1'b1, 1'b0};
        vecs[7] = '{5'b01000, 4'b1000, 1'b1, 1'b1};
        vecs[8] = '{5'b00000, 4'b1111, 1'b0, 1'b0};
        vecs[9] = '{5'b00110, 4'b0110, 1'b1, 1'b1};

        rst = 1'b1; sel = 1'b0; si = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0;
        ctl = 4'b0000; aux = 1'b1;
        @(negedge tck); #1;
        check("reset_so", so, 1'b0);
        check("reset_stable", stable, 1'b1);
        @(posedge tck); #1;
        rst = 1'b0; sel = 1'b1;

        // Closed SIB: 1-bit chain, capture loads stable_block
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("closed_capture", so_seen, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("closed_shift", so_seen, 1'b0);
        aux = 1'b0; #1;
        check("aux_low_comb", stable, 1'b0);
        aux = 1'b1; #1;
        check("aux_high_comb", stable, 1'b1);

        // Open the SIB
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        for (int r = 0; r < 10; r++) begin
            ctl = vecs[r].ctl;
            aux = vecs[r].aux;
            program_cfg(vecs[r].cfg);
            check($sformatf("mask_vec%0d", r), stable, vecs[r].exp);
        end

        // Debounce: update edge is edge 1, ctl[2] glitch on edge 5 restarts the count
        ctl = 4'b1111; aux = 1'b1;
        program_cfg(5'b11111);
        check("deb_edge1", stable, 1'b0);
        for (int e = 2; e <= 4; e++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("deb_edge%0d", e), stable, 1'b0);
        end
        ctl = 4'b1011;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("deb_glitch", stable, 1'b0);
        ctl = 4'b1111;
        for (int j = 1; j <= 8; j++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("deb_restart%0d", j), stable, j == 8);
        end

        // Sticky drop
        aux = 1'b0; #1;
        check("deb_registered", stable, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("deb_drop", stable, 1'b0);
        aux = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        read_chain("sticky1", 6'b111110);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        read_chain("sticky2", 6'b011110);

        // Capture ordering with dbe=0, en=0
        program_cfg(5'b00000);
        ctl = 4'b1001;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        read_chain("order", 6'b010011);

        // Reset mid-shift with counter at 5
        ctl = 4'b1111;
        program_cfg(5'b11111);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("pre_reset_stable", stable, 1'b0);
        rst = 1'b1; #1;
        check("rst_stable_aux1", stable, 1'b1);
        aux = 1'b0; #1;
        check("rst_stable_aux0", stable, 1'b0);
        aux = 1'b1;
        @(negedge tck); #1;
        check("rst_so", so, 1'b0);
        @(posedge tck); #1;
        rst = 1'b0;
        ctl = 4'b0000; #1;
        check("post_rst_mask", stable, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("post_rst_sib", so_seen, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("post_rst_closed", so_seen, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
